// File: rtl/cmp_pkg.sv
// Shared types for the serial comparator: controller states and the
// one-hot {eq, gt, lt} result encodings.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/serial_compare_ctrl_compare.sv
// Shared 1-bit equality cell; purely combinational, one instance serves any
// operand width when driven serially.
module compare (
  input  logic a,
  input  logic b,
  output logic equal
);

  assign equal = ~(a ^ b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Streams two latched operands MSB-first through a single 1-bit compare cell,
// stopping at the first mismatch and reporting eq/gt/lt with a done pulse.
module serial_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  output logic                     busy,
  output logic                     done,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic [$clog2(WIDTH):0]   bits_used
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_bits_used;
  logic [2:0]       r_res;
  logic             r_busy;
  logic             r_done;

  logic w_a_msb;
  logic w_b_msb;
  logic w_equal;

  assign w_a_msb = r_sa[WIDTH-1];
  assign w_b_msb = r_sb[WIDTH-1];

  compare u_compare (
    .a     (w_a_msb),
    .b     (w_b_msb),
    .equal (w_equal)
  );

  // r_cnt counts the scan in progress; r_bits_used only changes on completion
  // so the reported count always belongs to the reported result.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
    // block rather than in the sensitivity list.
    if (rst) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_bits_used <= '0;
      r_res       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: default-low here makes done a single-cycle pulse without a
      // separate clear path in every state.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a_in;
            r_sb    <= b_in;
            r_idx   <= IW'(WIDTH - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_equal) begin
            r_res       <= w_a_msb ? GT : LT;
            r_bits_used <= r_cnt + 1'b1;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else if (r_idx == '0) begin
            r_res       <= EQ;
            r_bits_used <= r_cnt + 1'b1;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
            r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign eq        = r_res[2];
  assign gt        = r_res[1];
  assign lt        = r_res[0];
  assign bits_used = r_bits_used;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: directed table, multi-cycle
// corner sequences and randomized operands against a arithmetic reference.
module tb_serial_compare_ctrl;

  localparam int W  = 8;
  localparam int BW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [BW-1:0] bits_used;

  int checks = 0;
  int errors = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .bits_used (bits_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   res;   // {eq, gt, lt}
    int           bits;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: equal operands scan all bits; otherwise the scan stops at the
  // highest differing bit and the larger operand wins.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2:0] res, output int bits);
    logic [W-1:0] x;
    x = a ^ b;
    if (a == b) begin
      res  = 3'b100;
      bits = W;
    end else begin
      res  = (a > b) ? 3'b010 : 3'b001;
      bits = 1;
      while (x[W-bits] == 1'b0) bits++;
    end
  endfunction

  // Called at a falling edge in IDLE; returns at a falling edge in IDLE.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy,
                         output int lat, output logic [2:0] res, output int bits,
                         output int ndone, output bit idle_ok);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    lat = -1; res = '0; bits = 0; ndone = 0; idle_ok = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= W + 4; c++) begin
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat  = c;
          res  = {eq, gt, lt};
          bits = int'(bits_used);
        end
      end
      if (lat >= 0 && c == lat + 1) begin
        idle_ok = !busy && !done;
        start = 1'b0;
        break;
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit noisy, input logic [2:0] exp_res, input int exp_bits);
    int lat, bits, ndone;
    logic [2:0] res;
    bit idle_ok;
    run_cmp(a, b, noisy, lat, res, bits, ndone, idle_ok);
    check({tag, " latency"}, 64'(lat), 64'(exp_bits + 1));
    check({tag, " result"}, 64'(res), 64'(exp_res));
    check({tag, " bits_used"}, 64'(bits), 64'(exp_bits));
    check({tag, " done_count"}, 64'(ndone), 64'd1);
    check({tag, " idle_after"}, 64'(idle_ok), 64'd1);
  endtask

  initial begin
    logic [2:0] m_res;
    int         m_bits;
    int         done_at[$];
    logic [W-1:0] ra, rb;

    tbl[0] = '{8'h5A, 8'h5A, 3'b100, 8};
    tbl[1] = '{8'h80, 8'h7F, 3'b010, 1};
    tbl[2] = '{8'h12, 8'h13, 3'b001, 8};
    tbl[3] = '{8'h01, 8'h00, 3'b010, 8};
    tbl[4] = '{8'hFF, 8'hFE, 3'b010, 8};
    tbl[5] = '{8'h00, 8'hFF, 3'b001, 1};
    tbl[6] = '{8'h0F, 8'h1F, 3'b001, 4};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, eq, gt, lt, bits_used}, '0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_no_start[%0d]", i), {busy, done, eq, gt, lt, bits_used}, '0);
    end

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("table[%0d]", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].res, tbl[i].bits);

    // Operands and start churn while busy: latched values must win.
    run_and_check("noisy_F0_E0", 8'hF0, 8'hE0, 1'b1, 3'b010, 4);

    // Reset in the middle of a scan: no done pulse, all outputs cleared.
    start = 1'b1; a_in = 8'h00; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_scan_reset_outputs", {busy, done, eq, gt, lt, bits_used}, '0);
    begin
      int pulses = 0;
      int nonzero = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) pulses++;
        if ({busy, eq, gt, lt, bits_used} != '0) nonzero++;
      end
      check("mid_scan_reset_no_done", 64'(pulses), 64'd0);
      check("mid_scan_reset_quiet", 64'(nonzero), 64'd0);
    end
    run_and_check("after_reset_01_00", 8'h01, 8'h00, 1'b0, 3'b010, 8);

    // start held high: equal operands re-accept every W+2 cycles.
    start = 1'b1; a_in = 8'hC3; b_in = 8'hC3;
    for (int c = 1; c <= 4 * (W + 2); c++) begin
      @(negedge clk);
      if (done) done_at.push_back(c);
      if (c % (W + 2) == 0)
        check($sformatf("b2b_idle_gap[%0d]", c), 64'(busy), 64'd0);
      if (c == 4 * (W + 2)) start = 1'b0;
    end
    check("b2b_done_count", 64'(done_at.size()), 64'd4);
    for (int k = 0; k < done_at.size() && k < 4; k++)
      check($sformatf("b2b_done_cycle[%0d]", k), 64'(done_at[k]), 64'((k + 1) * (W + 2) - 1));
    check("b2b_result_eq", {eq, gt, lt, bits_used}, {3'b100, BW'(W)});
    @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = W'($urandom);
        1: rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      model(ra, rb, m_res, m_bits);
      run_and_check($sformatf("rand[%0d] a=%0h b=%0h", t, ra, rb), ra, rb,
                    1'($urandom_range(0, 1)), m_res, m_bits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequencing controller that compares two WIDTH-bit operands by streaming them MSB-first through a single 1-bit `compare` cell (ports a, b, equal). It accepts a start request, latches both operands, walks the bits one per cycle, and stops at the first mismatch. It reports equal/greater/less with a one-cycle done pulse. It sits between a requesting block and the shared 1-bit equality datapath, so one cell serves arbitrarily wide comparisons.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- a_in  in  WIDTH  operand A, sampled on the accepted start cycle
- b_in  in  WIDTH  operand B, sampled on the accepted start cycle
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; result valid from this cycle
- eq  out  1  A == B
- gt  out  1  A > B (unsigned)
- lt  out  1  A < B (unsigned)
- bits_used  out  $clog2(WIDTH)+1  number of bit positions examined for the last result

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE + start: latch a_in/b_in into shift registers sa/sb, set idx = WIDTH-1, clear bits_used, go to SCAN. IDLE without start: stay.
- SCAN: drive compare.a = sa[WIDTH-1] and compare.b = sb[WIDTH-1]; increment bits_used.
  - compare.equal = 0: latch gt = sa[WIDTH-1], lt = ~sa[WIDTH-1], eq = 0, go to DONE.
  - compare.equal = 1 and idx == 0: latch eq = 1, gt = lt = 0, go to DONE.
  - Otherwise: shift sa/sb left by one, decrement idx, stay in SCAN.
- DONE: done = 1 for exactly this cycle, then IDLE unconditionally. A start in the DONE cycle is ignored.
- start while busy: ignored; the latched operands are unaffected by changes on a_in/b_in.
- eq/gt/lt/bits_used hold their last result until the next completion. They are not cleared on a new accept.
- Exactly one of eq/gt/lt is high after any completion. All three are 0 only after reset, before the first completion.
- The compare cell is purely combinational. The controller registers all outputs.

## Timing
- Cycle 0: start sampled high in IDLE. Cycle 1: first SCAN (MSB).
- First mismatch at bit i: SCAN covers cycles 1..WIDTH-i, DONE (done pulse) at cycle WIDTH-i+1, bits_used = WIDTH-i.
- Equal operands: done at cycle WIDTH+1, bits_used = WIDTH.
- busy = 1 in SCAN and DONE, 0 in IDLE. The earliest next accept is the cycle after DONE.
- Reset values: state IDLE, busy 0, done 0, eq 0, gt 0, lt 0, bits_used 0, sa/sb/idx 0.
- rst asserted mid-scan: next cycle is IDLE with all outputs at reset values. No done pulse and no partial result is produced. rst has priority over start.

## Structure
- Shared package `cmp_pkg`: state enum (IDLE, SCAN, DONE) and the result-encoding constants (EQ, GT, LT).
- One sub-module: the existing 1-bit `compare` cell, instantiated once as `u_compare`. All sequencing lives in `serial_compare_ctrl`.
- The bit counter width and bits_used width are derived from WIDTH via $clog2.

## Test plan
- Reset then idle, no start: busy = done = eq = gt = lt = 0 and bits_used = 0 for 20 cycles.
- WIDTH=8, start with A=8'h5A, B=8'h5A: done at cycle 9, eq = 1, gt = lt = 0, bits_used = 8.
- A=8'h80, B=8'h7F: mismatch at the MSB, done at cycle 2, gt = 1, bits_used = 1. Then A=8'h12, B=8'h13: done at cycle 9, lt = 1, bits_used = 8.
- A=8'hF0, B=8'hE0 with a_in/b_in toggled randomly and start pulsed during busy: gt = 1 and bits_used = 4 at cycle 5. There is exactly one done pulse and the extra starts are ignored.
- rst raised at cycle 3 of an A=8'h00, B=8'h00 compare: all outputs return to 0 and no done pulse follows. A new start with A=8'h01, B=8'h00 then yields gt = 1 at cycle 9.
- Back-to-back: start held high continuously. Accepts occur every WIDTH+2 cycles for equal operands, and start is ignored in the DONE cycle.
